// File: rtl/flash_op_sched.sv
// flash_op_sched: round-robin owner of the NOR flash pins, launching one engine op at a time with guard gap and watchdog
module flash_op_sched #(
    parameter int GUARD_CYC   = 20,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int TO_W        = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [3:0]   req_cmd,
    input  logic [49:0]  req_addr,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic [1:0]   err,
    output logic         busy,
    output logic [3:0]   eng_start,
    output logic [3:0]   eng_abort,
    output logic [24:0]  eng_addr,
    input  logic [3:0]   eng_done,
    input  logic [191:0] eng_bus,
    output logic [47:0]  flash_bus
);
    localparam logic [47:0] IDLE_BUS = 48'hFC00_0000_0000;
    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_GUARD, S_FIN} state_t;
    state_t state, nxt;
    logic [TO_W-1:0] cnt;
    logic [1:0] cmd, e;
    logic own, last, stage2, err_flag, w, take, eng_hit, to_hit, guard_end, erase_more, abort_c;
    assign take       = state == S_IDLE && |req;
    assign w          = &req ? ~last : req[1];
    assign e          = cmd == 2'd0 ? 2'd3 : cmd == 2'd1 ? 2'd2 : (cmd == 2'd2 && stage2) ? 2'd1 : 2'd0;
    assign eng_hit    = eng_done[e];
    assign to_hit     = cnt == TO_W'(TIMEOUT_CYC - 1);
    assign guard_end  = cnt == TO_W'(GUARD_CYC - 1);
    assign erase_more = cmd == 2'd2 && !stage2 && !err_flag;
    assign abort_c    = state == S_WAIT && to_hit && !eng_hit;
    always_ff @(posedge clk)
        state <= rst ? S_IDLE : nxt;
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = |req ? S_START : S_IDLE;
            S_START: nxt = S_WAIT;
            S_WAIT:  nxt = (eng_hit || to_hit) ? S_GUARD : S_WAIT;
            S_GUARD: nxt = !guard_end ? S_GUARD : erase_more ? S_START : S_FIN;
            default: nxt = S_IDLE;
        endcase
    end
    // one counter serves as watchdog in WAIT and guard timer in GUARD; cleared on every state change
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            cmd       <= '0;
            own       <= 1'b0;
            last      <= 1'b1;
            stage2    <= 1'b0;
            err_flag  <= 1'b0;
            eng_addr  <= '0;
            flash_bus <= IDLE_BUS;
        end else begin
            cnt       <= state != nxt ? '0 : cnt + 1'b1;
            flash_bus <= (state == S_WAIT && !eng_hit && !to_hit) ? eng_bus[48*int'(e) +: 48] : IDLE_BUS;
            if (take) begin
                cmd      <= w ? req_cmd[3:2] : req_cmd[1:0];
                eng_addr <= w ? req_addr[49:25] : req_addr[24:0];
                own      <= w;
                last     <= w;
                stage2   <= 1'b0;
                err_flag <= 1'b0;
            end
            if (state == S_GUARD && guard_end && erase_more)
                stage2 <= 1'b1;
            if (abort_c)
                err_flag <= 1'b1;
        end
    end
    always_comb begin
        gnt       = '0;
        done      = '0;
        err       = '0;
        eng_start = '0;
        eng_abort = '0;
        busy      = !rst && (take || state == S_START || state == S_WAIT || state == S_GUARD);
        if (!rst) begin
            gnt[w]       = take;
            eng_start[e] = state == S_START;
            eng_abort[e] = abort_c;
            err[own]     = abort_c;
            done[own]    = state == S_FIN && !err_flag;
        end
    end
endmodule

// File: tb/tb_flash_op_sched.sv
// tb_flash_op_sched: table-driven and directed checks of the flash op scheduler with a timer-based engine model
module tb_flash_op_sched;
    localparam int GC = 20;
    localparam int TO = 100;
    localparam logic [47:0] IDLE_BUS = 48'hFC00_0000_0000;

    logic clk = 1'b0, rst;
    logic [1:0] req, gnt, done, err;
    logic [3:0] req_cmd, eng_start, eng_abort, eng_done;
    logic [49:0] req_addr;
    logic busy;
    logic [24:0] eng_addr;
    logic [191:0] eng_bus;
    logic [47:0] flash_bus;

    int checks = 0, errors = 0;
    int cyc = 0;
    int dly[4], tmr[4];
    logic [3:0] inj = '0;

    int gnt_n[2], done_n[2], err_n[2], start_n[4], abort_n[4];
    int t_gnt, t_done, t_err, t_abort, t_fall, multi = 0, bus_bad;
    int t_start[4], t_edone[4];
    logic [24:0] addr_st[4];
    int gq[$], gtq[$], dq[$];
    logic [47:0] exp_fb = IDLE_BUS;
    bit in_wait = 0;
    int ae = 0;
    logic prev_busy = 1'b0;

    typedef struct {
        int r;
        logic [1:0] cmd;
        logic [24:0] addr;
        int edly;
        int x_eng;
        int x_done;
    } vec_t;
    vec_t tv[6];

    flash_op_sched #(.GUARD_CYC(GC), .TIMEOUT_CYC(TO), .TO_W(26)) dut (
        .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .req_addr(req_addr),
        .gnt(gnt), .done(done), .err(err), .busy(busy),
        .eng_start(eng_start), .eng_abort(eng_abort), .eng_addr(eng_addr),
        .eng_done(eng_done), .eng_bus(eng_bus), .flash_bus(flash_bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // engine model: done fires a programmed number of cycles after start; pins are random noise
    initial begin
        eng_done = '0;
        eng_bus  = '0;
        forever begin
            @(posedge clk);
            #1;
            eng_done = inj;
            inj = '0;
            for (int i = 0; i < 4; i++)
                if (tmr[i] > 0) begin
                    tmr[i]--;
                    if (tmr[i] == 0) eng_done[i] = 1'b1;
                end
            eng_bus = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        end
    end

    always @(negedge clk) begin
        if (flash_bus !== exp_fb) bus_bad++;
        exp_fb = (!rst && in_wait && !eng_done[ae] && eng_abort == 0) ? eng_bus[48*ae +: 48] : IDLE_BUS;
        if (rst || eng_done[ae] || eng_abort != 0) in_wait = 0;
        for (int i = 0; i < 2; i++) begin
            if (gnt[i]) begin gnt_n[i]++; t_gnt = cyc; gq.push_back(i); gtq.push_back(cyc); end
            if (done[i]) begin done_n[i]++; t_done = cyc; dq.push_back(cyc); end
            if (err[i]) begin err_n[i]++; t_err = cyc; end
        end
        for (int i = 0; i < 4; i++) begin
            if (eng_start[i]) begin
                start_n[i]++; t_start[i] = cyc; addr_st[i] = eng_addr; ae = i; in_wait = 1;
                if (dly[i] > 0) tmr[i] = dly[i];
            end
            if (eng_abort[i]) begin abort_n[i]++; t_abort = cyc; end
            if (eng_done[i]) t_edone[i] = cyc;
        end
        if ($countones(gnt) > 1 || $countones(done) > 1 || $countones(err) > 1 ||
            $countones(eng_start) > 1 || $countones(eng_abort) > 1) multi++;
        if (prev_busy && !busy) t_fall = cyc;
        prev_busy = busy;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        gnt_n = '{0, 0}; done_n = '{0, 0}; err_n = '{0, 0};
        start_n = '{0, 0, 0, 0}; abort_n = '{0, 0, 0, 0};
        tmr = '{0, 0, 0, 0}; dly = '{0, 0, 0, 0};
        t_gnt = -1; t_done = -1; t_err = -1; t_abort = -1; t_fall = -1; bus_bad = 0;
        gq.delete(); gtq.delete(); dq.delete();
    endtask

    task automatic rst_dut();
        adv(); rst = 1'b1;
        adv(); adv(); rst = 1'b0;
    endtask

    task automatic do_op(input int r, input logic [1:0] cmd, input logic [24:0] addr);
        bit ok = 0;
        adv();
        req[r] = 1'b1;
        req_cmd[2*r +: 2] = cmd;
        req_addr[25*r +: 25] = addr;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (gnt[r]) begin ok = 1; break; end
        end
        chk("gnt_wait", ok, 1);
        adv();
        req[r] = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        chk("idle_wait", ok, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] seq;
        tv[0] = '{0, 2'd0, 25'h0000100, 50, 3, 1};
        tv[1] = '{1, 2'd1, 25'h00ABCDE, 7, 2, 1};
        tv[2] = '{0, 2'd3, 25'h1FFFFFF, 1, 0, 1};
        tv[3] = '{1, 2'd0, 25'h0000000, 3, 3, 1};
        tv[4] = '{0, 2'd1, 25'h1234567, 99, 2, 1};
        tv[5] = '{1, 2'd3, 25'h0F0F0F0, 100, 0, 1};
        rst = 1'b1; req = '0; req_cmd = '0; req_addr = '0;
        clr();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_start", eng_start, 0);
        chk("rst_abort", eng_abort, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", eng_addr, 0);
        chk("rst_bus", flash_bus, IDLE_BUS);
        adv();
        rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            clr();
            dly[tv[k].x_eng] = tv[k].edly;
            do_op(tv[k].r, tv[k].cmd, tv[k].addr);
            wait_idle(300);
            chk($sformatf("v%0d_gnt", k), gnt_n[tv[k].r], 1);
            chk($sformatf("v%0d_gnt_other", k), gnt_n[1-tv[k].r], 0);
            chk($sformatf("v%0d_start", k), start_n[tv[k].x_eng], 1);
            chk($sformatf("v%0d_starts", k), start_n[0] + start_n[1] + start_n[2] + start_n[3], 1);
            chk($sformatf("v%0d_addr", k), addr_st[tv[k].x_eng], tv[k].addr);
            chk($sformatf("v%0d_start_lat", k), t_start[tv[k].x_eng] - t_gnt, 1);
            chk($sformatf("v%0d_done", k), done_n[tv[k].r], tv[k].x_done);
            chk($sformatf("v%0d_done_lat", k), t_done - t_edone[tv[k].x_eng], GC + 1);
            chk($sformatf("v%0d_err", k), err_n[0] + err_n[1], 0);
            chk($sformatf("v%0d_bus", k), bus_bad, 0);
        end

        clr();
        dly[0] = 5; dly[1] = 8;
        do_op(1, 2'd2, 25'h1000000);
        wait_idle(400);
        chk("er_unlock", start_n[0], 1);
        chk("er_erase", start_n[1], 1);
        chk("er_gap", t_start[1] - t_edone[0], GC + 1);
        chk("er_addr", addr_st[1], 25'h1000000);
        chk("er_done", done_n[1], 1);
        chk("er_done_lat", t_done - t_edone[1], GC + 1);
        chk("er_err", err_n[1], 0);
        chk("er_bus", bus_bad, 0);

        rst_dut();
        clr();
        dly[2] = 2;
        req_cmd = 4'b0101;
        req_addr = {25'h1AAAAAA, 25'h0155555};
        req = 2'b11;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            if (gq.size() >= 4) break;
        end
        #1;
        req = 2'b00;
        chk("rr_count", gq.size() >= 4, 1);
        seq = '0;
        for (int k = 0; k < 4 && k < gq.size(); k++) seq[3-k] = gq[k][0];
        chk("rr_order", seq, 4'b0101);
        chk("rr_regrant", (gtq.size() > 1 && dq.size() > 0) ? gtq[1] - dq[0] : -1, 1);
        wait_idle(200);

        clr();
        dly[0] = 3;
        do_op(0, 2'd2, 25'h0000042);
        wait_idle(400);
        chk("to_abort", abort_n[1], 1);
        chk("to_err", err_n[0], 1);
        chk("to_when", t_abort - t_start[1], TO);
        chk("to_err_when", t_err - t_abort, 0);
        chk("to_nodone", done_n[0], 0);
        chk("to_fin", t_fall - t_abort, GC + 1);
        chk("to_bus", bus_bad, 0);

        clr();
        do_op(1, 2'd2, 25'h0000777);
        wait_idle(400);
        chk("tu_abort", abort_n[0], 1);
        chk("tu_err", err_n[1], 1);
        chk("tu_skip", start_n[1], 0);
        chk("tu_nodone", done_n[1], 0);

        clr();
        do_op(0, 2'd1, 25'h00055AA);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        adv();
        rst = 1'b0;
        inj = 4'b0100;
        @(negedge clk);
        chk("mr_bus", flash_bus, IDLE_BUS);
        chk("mr_busy", busy, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("mr_done", done_n[0] + done_n[1], 0);
        chk("mr_err", err_n[0] + err_n[1], 0);
        chk("mr_restart", start_n[0] + start_n[1] + start_n[2] + start_n[3], 1);
        chk("mr_bus_all", bus_bad, 0);

        clr();
        dly[2] = 30;
        do_op(1, 2'd1, 25'h0ABCDE);
        repeat (8) @(posedge clk);
        #1;
        inj = 4'b1000;
        wait_idle(300);
        chk("we_done", done_n[1], 1);
        chk("we_done_lat", t_done - t_edone[2], GC + 1);
        chk("we_stray_seen", t_edone[3] < t_edone[2], 1);
        chk("we_nostart", start_n[3], 0);
        chk("we_bus", bus_bad, 0);

        chk("onehot", multi, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
